clk_gate_ctrl: RTL and testbench

Clock-enable controller that drives the enable input of the latch-based clock gate feeding the ALU clock domain. It turns the gated clock on when a requester needs it, waits a fixed settle time before signalling readiness, and switches the clock off again after a programmable idle window. It also keeps a saturating count of enabled cycles for power monitoring. It sits in the always-on reference-clock domain, between the system controller and the clock gate.

---
 rtl/clk_gate_ctrl.sv | 145 ++++++++++++++
 tb/tb_clk_gate_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_gate_ctrl.sv
// Purpose: drives the enable of the latch-based clock gate for the ALU domain; counts enabled cycles.
// Latency: clk_en rises 1 edge after activity is sampled; ready follows WAKE_CYCLES edges later; outputs are registered.
// Backpressure: none; busy/force_on hold the clock on, and the clock drops after IDLE_TIMEOUT idle cycles.
//
// Ports:
//   clk           reference clock, ungated (always-on domain)
//   rst_n         asynchronous active-low reset
//   req           requester needs the gated clock
//   busy          gated domain still working, keeps the clock on
//   force_on      test/scan override, behaves exactly like req
//   cnt_clr       synchronous clear of gated_cycles (wins over increment)
//   clk_en        enable to the clock gate, registered and glitch-free
//   ready         gated clock running and settled
//   gated_cycles  saturating count of cycles with clk_en=1
module clk_gate_ctrl #(
    parameter int WAKE_CYCLES  = 2,   // legal 1..15
    parameter int IDLE_TIMEOUT = 4,   // legal 1..15
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    input  logic                 busy,
    input  logic                 force_on,
    input  logic                 cnt_clr,
    output logic                 clk_en,
    output logic                 ready,
    output logic [CNT_WIDTH-1:0] gated_cycles
);

    typedef enum logic [1:0] {
        S_OFF       = 2'd0,
        S_WAKE      = 2'd1,
        S_ON        = 2'd2,
        S_IDLE_WAIT = 2'd3
    } state_t;

    localparam logic [3:0]           WAKE_LOAD = 4'(WAKE_CYCLES - 1);
    localparam logic [3:0]           IDLE_LOAD = 4'(IDLE_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    state_t     state_q;
    state_t     state_nxt;
    logic [3:0] cnt_q;
    logic [3:0] cnt_nxt;
    logic       clk_en_nxt;
    logic       ready_nxt;
    logic       act;

    assign act = req | busy | force_on;

    // State register. Outputs are registered alongside the state so they
    // move on the same edge and the gate enable never sees a comb glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_OFF;
            cnt_q   <= 4'd0;
            clk_en  <= 1'b0;
            ready   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            clk_en  <= clk_en_nxt;
            ready   <= ready_nxt;
        end
    end

    // Next-state logic. cnt is shared by the settle and idle windows.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        unique case (state_q)
            S_OFF: begin
                if (act) begin
                    state_nxt = S_WAKE;
                    cnt_nxt   = WAKE_LOAD;
                end
            end
            S_WAKE: begin
                // Settle time always completes, even if activity goes away.
                if (cnt_q == 4'd0) begin
                    state_nxt = S_ON;
                end else begin
                    cnt_nxt = cnt_q - 4'd1;
                end
            end
            S_ON: begin
                if (!act) begin
                    state_nxt = S_IDLE_WAIT;
                    cnt_nxt   = IDLE_LOAD;
                end
            end
            S_IDLE_WAIT: begin
                // Renewed activity beats expiry in the same cycle.
                if (act) begin
                    state_nxt = S_ON;
                end else if (cnt_q == 4'd0) begin
                    state_nxt = S_OFF;
                end else begin
                    cnt_nxt = cnt_q - 4'd1;
                end
            end
            default: begin
                state_nxt = S_OFF;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Output decode from the next state, registered above.
    always_comb begin
        clk_en_nxt = 1'b0;
        ready_nxt  = 1'b0;
        unique case (state_nxt)
            S_OFF: begin
                clk_en_nxt = 1'b0;
                ready_nxt  = 1'b0;
            end
            S_WAKE: begin
                clk_en_nxt = 1'b1;
                ready_nxt  = 1'b0;
            end
            S_ON, S_IDLE_WAIT: begin
                clk_en_nxt = 1'b1;
                ready_nxt  = 1'b1;
            end
            default: begin
                clk_en_nxt = 1'b0;
                ready_nxt  = 1'b0;
            end
        endcase
    end

    // Enabled-cycle counter: counts the registered enable, saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gated_cycles <= '0;
        end else if (cnt_clr) begin
            gated_cycles <= '0;
        end else if (clk_en && (gated_cycles != CNT_MAX)) begin
            gated_cycles <= gated_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
module tb_clk_gate_ctrl;

    localparam int W = 2;
    localparam int I = 4;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        busy;
    logic        force_on;
    logic        cnt_clr;
    logic        clk_en;
    logic        ready;
    logic [15:0] gated_cycles;
    logic        clk_en_s;
    logic        ready_s;
    logic [3:0]  gated_cycles_s;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: enable flag, ready flag, edges since wake began,
    // consecutive idle samples seen while ready, and two saturating counts.
    bit m_en;
    bit m_rdy;
    int m_age;
    int m_idle;
    int m_cnt16;
    int m_cnt4;

    clk_gate_ctrl #(.WAKE_CYCLES(W), .IDLE_TIMEOUT(I), .CNT_WIDTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .busy         (busy),
        .force_on     (force_on),
        .cnt_clr      (cnt_clr),
        .clk_en       (clk_en),
        .ready        (ready),
        .gated_cycles (gated_cycles)
    );

    clk_gate_ctrl #(.WAKE_CYCLES(W), .IDLE_TIMEOUT(I), .CNT_WIDTH(4)) dut_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .busy         (busy),
        .force_on     (force_on),
        .cnt_clr      (cnt_clr),
        .clk_en       (clk_en_s),
        .ready        (ready_s),
        .gated_cycles (gated_cycles_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_en    = 0;
        m_rdy   = 0;
        m_age   = 0;
        m_idle  = 0;
        m_cnt16 = 0;
        m_cnt4  = 0;
    endtask

    task automatic model_edge();
        bit act;
        act = req | busy | force_on;
        if (cnt_clr) begin
            m_cnt16 = 0;
            m_cnt4  = 0;
        end else if (m_en) begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt4 < 15) m_cnt4++;
        end
        if (!m_en) begin
            if (act) begin
                m_en  = 1;
                m_rdy = 0;
                m_age = 0;
            end
        end else if (!m_rdy) begin
            m_age++;
            if (m_age == W) begin
                m_rdy  = 1;
                m_idle = 0;
            end
        end else if (act) begin
            m_idle = 0;
        end else begin
            m_idle++;
            if (m_idle > I) begin
                m_en  = 0;
                m_rdy = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("clk_en", 32'(clk_en), 32'(m_en));
        chk("ready", 32'(ready), 32'(m_rdy));
        chk("gated_cycles", 32'(gated_cycles), 32'(m_cnt16));
        chk("clk_en_sat", 32'(clk_en_s), 32'(m_en));
        chk("gated_cycles_sat", 32'(gated_cycles_s), 32'(m_cnt4));
    endtask

    // One clock: model follows the edge, outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_in(input bit r, input bit b, input bit f, input bit c);
        req      = r;
        busy     = b;
        force_on = f;
        cnt_clr  = c;
    endtask

    // Mid-cycle async reset: outputs must fall before any clock edge.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        chk({tag, "_clk_en"}, 32'(clk_en), 32'd0);
        chk({tag, "_ready"}, 32'(ready), 32'd0);
        chk({tag, "_cnt"}, 32'(gated_cycles), 32'd0);
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int hi;
        int mode;
        rst_n = 1'b0;
        set_in(0, 0, 0, 0);
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Quiet after reset: stays off.
        for (int i = 0; i < 3; i++) tick();

        // Wake then release with explicit latency checks.
        set_in(1, 0, 0, 0);
        tick();
        chk("wake_en_k", 32'(clk_en), 32'd1);
        chk("wake_rdy_k", 32'(ready), 32'd0);
        tick();
        chk("wake_rdy_k1", 32'(ready), 32'd0);
        tick();
        chk("wake_rdy_k2", 32'(ready), 32'd1);
        for (int i = 0; i < 3; i++) tick();
        set_in(0, 0, 0, 0);
        for (int i = 0; i < I; i++) begin
            tick();
            chk("release_hold_en", 32'(clk_en), 32'd1);
        end
        // Idle counter now at its last cycle; busy arrives just in time.
        set_in(0, 1, 0, 0);
        tick();
        chk("busy_at_expiry_en", 32'(clk_en), 32'd1);
        chk("busy_at_expiry_rdy", 32'(ready), 32'd1);
        set_in(0, 0, 0, 0);
        for (int i = 0; i < I; i++) begin
            tick();
            chk("fresh_window_en", 32'(clk_en), 32'd1);
        end
        tick();
        chk("release_en_off", 32'(clk_en), 32'd0);
        chk("release_rdy_off", 32'(ready), 32'd0);

        // One-cycle pulse from OFF.
        set_in(0, 0, 0, 1);
        tick();
        set_in(1, 0, 0, 0);
        tick();
        hi = clk_en ? 1 : 0;
        set_in(0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (clk_en) hi++;
        end
        chk("pulse_len", 32'(hi), 32'd7);
        chk("pulse_cnt", 32'(gated_cycles), 32'd7);

        // Saturation of the narrow counter, then clear and resume.
        set_in(0, 0, 1, 1);
        tick();
        set_in(0, 0, 1, 0);
        for (int i = 0; i < 20; i++) tick();
        chk("sat_hold", 32'(gated_cycles_s), 32'd15);
        set_in(0, 0, 1, 1);
        tick();
        chk("sat_clr", 32'(gated_cycles_s), 32'd0);
        set_in(0, 0, 1, 0);
        tick();
        chk("sat_resume", 32'(gated_cycles_s), 32'd1);
        set_in(0, 0, 0, 0);
        for (int i = 0; i < 20; i++) tick();

        // Reset during WAKE.
        set_in(1, 0, 0, 0);
        tick();
        async_reset("rst_wake");
        set_in(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick();

        // Reset during IDLE_WAIT.
        set_in(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick();
        set_in(0, 0, 0, 0);
        tick();
        tick();
        async_reset("rst_idle");
        for (int i = 0; i < 3; i++) tick();
        set_in(0, 1, 0, 0);
        tick();
        chk("post_rst_wake", 32'(clk_en), 32'd1);

        // Randomised traffic with varying activity density.
        mode = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 32 == 0) mode = $urandom_range(0, 2);
            case (mode)
                0: set_in($urandom_range(0, 15) == 0, 1'b0, 1'b0, $urandom_range(0, 63) == 0);
                1: set_in($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                          $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
                default: set_in($urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0,
                                1'b0, $urandom_range(0, 127) == 0);
            endcase
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
